// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M multiply/divide unit for the EX stage.
// Multiplication is iterative shift-add and division is restoring division.
// Both work one bit per cycle on operand magnitudes, and the sign is fixed up
// when the last iteration completes.
// Optional build macro EX_MULDIV_FAST_MUL_EN replaces the iterative multiplier
// with a single-cycle 33x33 signed multiplier. Division stays iterative.
// Handshake: the caller holds start with funct3/op1/op2 for one cycle. The
// request is taken when the unit is in IDLE or DONE and flush is low.
// stall_req stays high from that cycle until the last iteration. done pulses
// for exactly one cycle in DONE. result then holds until the next completion.
module ex_muldiv #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  stall_req,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Registers latched at accept time.
   logic [63:0] p_q;     // mul: {acc, multiplier}; div: {remainder, quotient}
   logic [31:0] a_q;     // mul: multiplicand magnitude; div: divisor magnitude
   logic [1:0]  f3_q;
   logic        neg_q;   // product/quotient sign
   logic        s1_q;    // remainder sign
   logic [4:0]  cnt_q;

   logic        accept, last;
   logic        op1_signed, op2_signed, s1, s2;
   logic [31:0] mag1, mag2;
   logic        div_zero, div_ovf;

   // Operand decode for the request in this cycle.
   always_comb begin
      op1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
      op2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      s1         = op1_signed & op1[31];
      s2         = op2_signed & op2[31];
      mag1       = s1 ? (32'd0 - op1) : op1;
      mag2       = s2 ? (32'd0 - op2) : op2;
      div_zero   = funct3[2] && (op2 == 32'd0);
      div_ovf    = funct3[2] && !funct3[0] &&
                   (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
   end

`ifdef EX_MULDIV_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
   logic signed [65:0] fast_prod;
   logic [31:0]        fast_res;
   assign fast_prod = $signed({s1, op1}) * $signed({s2, op2});
   assign fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
`else
   localparam bit FAST_MUL = 1'b0;
`endif

   // One iteration step of each datapath, plus the sign-corrected final values.
   logic [32:0] mul_sum;
   logic [63:0] mul_p, prod_fix, div_p;
   logic [32:0] div_sh;
   logic        div_ge;
   logic [31:0] div_sub, mul_fin, div_fin;

   always_comb begin
      mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
      mul_p    = {mul_sum, p_q[31:1]};
      prod_fix = neg_q ? (64'd0 - mul_p) : mul_p;
      mul_fin  = (f3_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
      div_sh   = {p_q[63:32], p_q[31]};
      div_ge   = div_sh >= {1'b0, a_q};
      div_sub  = div_sh[31:0] - a_q;
      div_p    = div_ge ? {div_sub, p_q[30:0], 1'b1} : {div_sh[31:0], p_q[30:0], 1'b0};
      if (f3_q[1])
         div_fin = s1_q ? (32'd0 - div_p[63:32]) : div_p[63:32];
      else
         div_fin = neg_q ? (32'd0 - div_p[31:0]) : div_p[31:0];
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic. Flush wins over both start and completion.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = (cnt_q == 5'd31);
      case (state)
         S_IDLE, S_DONE: begin
            state_nxt = S_IDLE;
            if (start && !flush && !rst) begin
               accept = 1'b1;
               if (funct3[2])
                  state_nxt = (div_zero || div_ovf) ? S_DONE : S_DIV;
               else
                  state_nxt = FAST_MUL ? S_DONE : S_MUL;
            end
         end
         S_MUL, S_DIV: begin
            if (flush)     state_nxt = S_IDLE;
            else if (last) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, iteration and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q    <= '0;
         a_q    <= '0;
         f3_q   <= '0;
         neg_q  <= 1'b0;
         s1_q   <= 1'b0;
         cnt_q  <= '0;
         result <= '0;
      end else if (accept) begin
         f3_q  <= funct3[1:0];
         neg_q <= s1 ^ s2;
         s1_q  <= s1;
         cnt_q <= '0;
         if (funct3[2]) begin
            a_q <= mag2;
            p_q <= {32'd0, mag1};
            if (div_zero)     result <= funct3[1] ? op1 : 32'hFFFF_FFFF;
            else if (div_ovf) result <= funct3[1] ? 32'd0 : 32'h8000_0000;
         end else begin
            a_q <= mag1;
            p_q <= {32'd0, mag2};
`ifdef EX_MULDIV_FAST_MUL_EN
            result <= fast_res;
`endif
         end
      end else if (!flush && (state == S_MUL || state == S_DIV)) begin
         cnt_q <= cnt_q + 5'd1;
         if (state == S_MUL) begin
            p_q <= mul_p;
            if (last) result <= mul_fin;
         end else begin
            p_q <= div_p;
            if (last) result <= div_fin;
         end
      end
   end

   assign busy      = (state == S_MUL) || (state == S_DIV);
   assign done      = (state == S_DONE);
   assign stall_req = busy || accept;
   assign state_dbg = state;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an
// arithmetic reference model.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op1, op2;
   logic        flush;
   logic        busy, done, stall_req;
   logic [31:0] result;
   logic [1:0]  state_dbg;

   int n_pass  = 0;
   int n_total = 0;

   ex_muldiv #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
      .flush(flush), .busy(busy), .done(done), .result(result),
      .stall_req(stall_req), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

`ifdef EX_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   // RV32M semantics using plain 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, p;
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      xa = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
      xb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = xa * xb;
      case (f3)
         3'b000:  model = p[31:0];
         3'b001, 3'b010, 3'b011: model = p[63:32];
         3'b100:  model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'b101:  model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110:  model = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: model = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return MUL_LAT;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: pick = 32'd0;
         1: pick = 32'd1;
         2: pick = 32'hFFFF_FFFF;
         3: pick = 32'h8000_0000;
         4: pick = 32'h7FFF_FFFF;
         default: pick = $urandom;
      endcase
   endfunction

   // Issue one operation from a negedge in IDLE/DONE and check it through completion.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [31:0] exp;
      int lat, cyc;
      exp = model(f3, a, b);
      lat = exp_lat(f3, a, b);
      funct3 = f3; op1 = a; op2 = b; start = 1'b1;
      #1;
      n_total++;
      if (stall_req !== 1'b1) $display("FAIL %s stall_req at start: got %b want 1", name, stall_req);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      n_total++;
      if (busy !== (lat > 1)) $display("FAIL %s busy first cycle: got %b want %b", name, busy, lat > 1);
      else n_pass++;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      n_total++;
      if (cyc != lat) $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
      else n_pass++;
      n_total++;
      if (result !== exp) $display("FAIL %s result: got %h want %h", name, result, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op1 = '0; op2 = '0;
      repeat (2) @(negedge clk);
      n_total++;
      if ({busy, done, stall_req} !== 3'b000) $display("FAIL reset flags: got %b want 000", {busy, done, stall_req});
      else n_pass++;
      n_total++;
      if (result !== 32'd0) $display("FAIL reset result: got %h want 0", result);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
      @(negedge clk);
      n_total++;
      if (done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", done);
      else n_pass++;
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
      issue(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh_min");
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      issue(3'b101, 32'd5, 32'd0, "divu_by0");
      issue(3'b111, 32'd5, 32'd0, "remu_by0");
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      issue(3'b101, 32'd100, 32'd7, "b2b_divu");
      issue(3'b000, 32'd12345, 32'd678, "b2b_mul");
      issue(3'b111, 32'd100, 32'd7, "b2b_remu");
      @(negedge clk);
   endtask

   task automatic test_flush();
      logic [31:0] prior;
      issue(3'b011, 32'd3, 32'd5, "flush_prior");
      prior = model(3'b011, 32'd3, 32'd5);
      // Flush in DONE suppresses a same-cycle start.
      flush = 1'b1; start = 1'b1; funct3 = 3'b100; op1 = 32'd9; op2 = 32'd2;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      n_total++;
      if ({busy, done} !== 2'b00) $display("FAIL flush_in_done state: got %b want 00", {busy, done});
      else n_pass++;
      // Flush an in-flight divide at N+10.
      funct3 = 3'b100; op1 = 32'hFFFF_FF9C; op2 = 32'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_total++;
      if ({busy, done} !== 2'b00) $display("FAIL flush_mid state: got %b want 00", {busy, done});
      else n_pass++;
      n_total++;
      if (result !== prior) $display("FAIL flush_mid result: got %h want %h", result, prior);
      else n_pass++;
      issue(3'b110, 32'hFFFF_FF9C, 32'd7, "after_flush");
      @(negedge clk);
   endtask

   task automatic test_rst_mid();
      int dones;
      funct3 = 3'b000; op1 = 32'd11; op2 = 32'd13; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if ({busy, done, stall_req} !== 3'b000) $display("FAIL rst_mid flags: got %b want 000", {busy, done, stall_req});
      else n_pass++;
      n_total++;
      if (result !== 32'd0) $display("FAIL rst_mid result: got %h want 0", result);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      n_total++;
      if (dones != 0) $display("FAIL rst_mid spurious done: got %0d want 0", dones);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         issue(f3, a, b, "random");
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation using this cycle's op1/op2/funct3.
REQ-005 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op1  input  DATA_WIDTH  rs1 operand, taken post-forwarding (Forward_op1).
REQ-007 SHALL have port op2  input  DATA_WIDTH  rs2 operand, taken post-forwarding (Forward_op2).
REQ-008 SHALL have port flush  input  1  abort the in-flight operation (branch/trap squash).
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port result  output  DATA_WIDTH  final result; held until the next accepted start.
REQ-012 SHALL have port stall_req  output  1  holds the IF/ID/EX pipeline registers.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in MUL/DIV SHALL be ignored.
REQ-015 On accepted start with funct3[2]=0, SHALL enter MUL; with funct3[2]=1, DIV; operands, funct3 and sign flags SHALL be latched.
REQ-016 MUL SHALL be iterative shift-add on operand magnitudes, one bit per cycle, 32 cycles; sign fixed up at completion (MULH: both signed; MULHSU: op1 signed; MULHU/MUL: unsigned/low word).
REQ-017 DIV SHALL be restoring division on magnitudes, 32 cycles; quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
REQ-018 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-019 Latency: start sampled at edge N -> iterations cycles N+1..N+32 -> DONE state during cycle N+33, done=1 for exactly that cycle.
REQ-020 Divide by zero SHALL skip iteration: DONE at N+1; DIV/DIVU result 0xFFFFFFFF; REM/REMU result op1.
REQ-021 Signed overflow (DIV/REM with op1=0x80000000, op2=0xFFFFFFFF) SHALL skip iteration: DONE at N+1; DIV 0x80000000, REM 0.
REQ-022 busy SHALL be 1 in MUL and DIV, 0 in IDLE and DONE.
REQ-023 stall_req SHALL be combinational: 1 when start is accepted and in MUL/DIV; 0 in DONE so the consuming instruction advances.
REQ-024 DONE SHALL return to IDLE next cycle unless a new start is accepted, then go to MUL/DIV.
REQ-025 flush SHALL take priority over start and completion: next state IDLE, no done pulse, result unchanged.
REQ-026 flush in IDLE or DONE SHALL have no effect other than forcing IDLE and suppressing any same-cycle start.

Reset
REQ-027 rst=1 SHALL asynchronously force state IDLE, busy=0, done=0, stall_req=0, result=0, internal registers 0.
REQ-028 rst asserted mid-operation SHALL discard the operation; no done after release.

Configuration
REQ-029 Macro EX_MULDIV_FAST_MUL_EN, when defined, SHALL compute all MUL* ops with a single-cycle 33x33 signed multiplier: DONE at N+1, MUL state unused.
REQ-030 Without EX_MULDIV_FAST_MUL_EN, multiplication SHALL be iterative per REQ-016/019; division is iterative in both builds.

Verification
REQ-031 MUL op1=7, op2=0xFFFFFFFD (-3) -> done at N+33, result 0xFFFFFFEB; stall_req high N..N+32.
REQ-032 MULHU op1=op2=0xFFFFFFFF -> result 0xFFFFFFFE; with EX_MULDIV_FAST_MUL_EN done at N+1.
REQ-033 DIV op1=0xFFFFFFF9 (-7), op2=2 -> result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-034 DIVU op1=5, op2=0 -> done at N+1, result 0xFFFFFFFF; REM op1=0x80000000, op2=0xFFFFFFFF -> 0.
REQ-035 DIV start, flush at N+10 -> IDLE at N+11, no done, result keeps prior value; next start accepted at N+11.
REQ-036 rst pulse at N+5 of MUL -> all outputs 0 immediately; no done after release.
